// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: turns EX/MEM load/store requests into valid/ready data-bus
// transactions, stalls the pipeline while a transaction is in flight and registers writeback.
module mem_access_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_result,
  input  logic [31:0] mem_op2_selected,
  input  logic        mem_memory_write,
  input  logic        mem_memory_read,
  input  logic [2:0]  mem_memory_load_type,
  input  logic [1:0]  mem_memory_store_type,
  input  logic        mem_wb_reg_file,
  input  logic [4:0]  mem_wb_rd,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_misaligned,
  output logic [31:0] wb_result,
  output logic        wb_reg_file,
  output logic [4:0]  wb_rd
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q;
  logic [31:0] load_data_q;

  logic        access, is_write, is_read, misaligned, start;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [31:0] load_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Write wins when both read and write are requested.
  assign is_write = mem_memory_write;
  assign is_read  = mem_memory_read & ~mem_memory_write;
  assign access   = mem_memory_write | mem_memory_read;

  always_comb begin
    misaligned = 1'b0;
    if (is_write) begin
      case (mem_memory_store_type)
        2'b00:   misaligned = 1'b0;
        2'b01:   misaligned = mem_result[0];
        default: misaligned = |mem_result[1:0];
      endcase
    end else if (is_read) begin
      case (mem_memory_load_type)
        3'b000, 3'b100: misaligned = 1'b0;
        3'b001, 3'b101: misaligned = mem_result[0];
        default:        misaligned = |mem_result[1:0];
      endcase
    end
  end

  assign start     = (state_q == StIdle) & access & ~misaligned;
  assign mem_stall = start | (state_q == StReq) | (state_q == StWait);

  always_comb begin
    st_wstrb = 4'b1111;
    st_wdata = mem_op2_selected;
    case (mem_memory_store_type)
      2'b00: begin
        st_wstrb = 4'b0001 << mem_result[1:0];
        st_wdata = {4{mem_op2_selected[7:0]}};
      end
      2'b01: begin
        st_wstrb = mem_result[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{mem_op2_selected[15:0]}};
      end
      default: begin
        st_wstrb = 4'b1111;
        st_wdata = mem_op2_selected;
      end
    endcase
  end

  // EX/MEM is frozen while stalled, so the address low bits are still valid in WAIT.
  assign ld_byte = dmem_rdata[{mem_result[1:0], 3'b000} +: 8];
  assign ld_half = mem_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    case (mem_memory_load_type)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_ext = {24'h0, ld_byte};
      3'b101:  load_ext = {16'h0, ld_half};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      load_data_q    <= 32'h0;
      dmem_req_valid <= 1'b0;
      dmem_addr      <= 32'h0;
      dmem_we        <= 1'b0;
      dmem_wstrb     <= 4'h0;
      dmem_wdata     <= 32'h0;
      mem_misaligned <= 1'b0;
      wb_result      <= 32'h0;
      wb_reg_file    <= 1'b0;
      wb_rd          <= 5'h0;
    end else begin
      mem_misaligned <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (access && misaligned) begin
            mem_misaligned <= 1'b1;
          end else if (access) begin
            dmem_addr      <= {mem_result[31:2], 2'b00};
            dmem_we        <= is_write;
            dmem_wstrb     <= is_write ? st_wstrb : 4'h0;
            dmem_wdata     <= st_wdata;
            dmem_req_valid <= 1'b1;
            state_q        <= StReq;
          end
        end
        StReq: begin
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            state_q        <= dmem_we ? StDone : StWait;
          end
        end
        StWait: begin
          if (dmem_rsp_valid) begin
            load_data_q <= load_ext;
            state_q     <= StDone;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      if (!mem_stall) begin
        wb_result   <= (state_q == StDone && is_read) ? load_data_q : mem_result;
        wb_reg_file <= mem_wb_reg_file & ~is_write &
                       ~((state_q == StIdle) & access & misaligned);
        wb_rd       <= mem_wb_rd;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized accesses
// against an arithmetic reference model of the load/store rules.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_result = 32'h0;
  logic [31:0] mem_op2_selected = 32'h0;
  logic        mem_memory_write = 1'b0;
  logic        mem_memory_read = 1'b0;
  logic [2:0]  mem_memory_load_type = 3'b0;
  logic [1:0]  mem_memory_store_type = 2'b0;
  logic        mem_wb_reg_file = 1'b0;
  logic [4:0]  mem_wb_rd = 5'h0;
  logic        dmem_req_valid;
  logic        dmem_req_ready = 1'b0;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        mem_stall;
  logic        mem_misaligned;
  logic [31:0] wb_result;
  logic        wb_reg_file;
  logic [4:0]  wb_rd;

  int total = 0;
  int bad = 0;

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .mem_result(mem_result), .mem_op2_selected(mem_op2_selected),
    .mem_memory_write(mem_memory_write), .mem_memory_read(mem_memory_read),
    .mem_memory_load_type(mem_memory_load_type), .mem_memory_store_type(mem_memory_store_type),
    .mem_wb_reg_file(mem_wb_reg_file), .mem_wb_rd(mem_wb_rd),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_misaligned(mem_misaligned),
    .wb_result(wb_result), .wb_reg_file(wb_reg_file), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic w, input logic [2:0] lt, input logic [1:0] st);
    if (w) return (st == 2'd0) ? 1 : (st == 2'd1) ? 2 : 4;
    if (lt == 3'd0 || lt == 3'd4) return 1;
    if (lt == 3'd1 || lt == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] lt, input logic [31:0] a,
                                         input logic [31:0] d);
    int sz;
    logic [31:0] v, span;
    sz = acc_size(1'b0, lt, 2'd0);
    if (sz == 4) return d;
    span = (sz == 1) ? 32'd256 : 32'd65536;
    v = (d >> (8 * ((sz == 1) ? (a % 4) : (a & 2)))) % span;
    if ((lt == 3'd0 || lt == 3'd1) && v >= span / 2) v = v - span;
    return v;
  endfunction

  function automatic logic [3:0] m_strb(input logic [1:0] st, input logic [31:0] a);
    int sz;
    sz = acc_size(1'b1, 3'd0, st);
    if (sz == 1) return 4'(1 << (a % 4));
    if (sz == 2) return 4'(3 << (a & 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] st, input logic [31:0] op2);
    int sz;
    sz = acc_size(1'b1, 3'd0, st);
    if (sz == 1) return (op2 % 256) * 32'h0101_0101;
    if (sz == 2) return (op2 % 65536) * 32'h0001_0001;
    return op2;
  endfunction

  // ---------------- driver / bus responder ----------------
  // Applies one op, plays the memory side, returns what it saw, then drives an ALU op (nres).
  task automatic do_access(input logic [31:0] res, op2, input logic w, r,
                           input logic [2:0] lt, input logic [1:0] st,
                           input logic rf, input logic [4:0] rd,
                           input int rdly, wdly, input logic [31:0] rdata, input logic early,
                           input logic [31:0] nres,
                           output int stalls, output int nreq, output logic unstable,
                           output logic [31:0] a, wd, output logic we, output logic [3:0] sb,
                           output logic tmo);
    int rq, wc;
    logic wt, fin;
    @(posedge clk); #1;
    mem_result = res; mem_op2_selected = op2; mem_memory_write = w; mem_memory_read = r;
    mem_memory_load_type = lt; mem_memory_store_type = st; mem_wb_reg_file = rf; mem_wb_rd = rd;
    stalls = 0; nreq = 0; unstable = 1'b0; a = '0; wd = '0; we = 1'b0; sb = '0;
    rq = 0; wc = 0; wt = 1'b0; fin = 1'b0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      @(negedge clk);
      if (!mem_stall) begin
        fin = 1'b1;
        break;
      end
      stalls++;
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      if (dmem_req_valid) begin
        if (rq == 0) begin
          a = dmem_addr; wd = dmem_wdata; we = dmem_we; sb = dmem_wstrb;
        end else if (a !== dmem_addr || wd !== dmem_wdata || we !== dmem_we ||
                     sb !== dmem_wstrb) begin
          unstable = 1'b1;
        end
        if (rq >= rdly) begin
          dmem_req_ready = 1'b1;
          nreq++;
          wt = ~dmem_we;
        end
        if (early && rq == 1) begin
          dmem_rsp_valid = 1'b1;
          dmem_rdata = ~rdata;
        end
        rq++;
      end else if (wt) begin
        if (wc >= wdly) begin
          dmem_rsp_valid = 1'b1;
          dmem_rdata = rdata;
          wt = 1'b0;
        end
        wc++;
      end
    end
    tmo = ~fin;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    mem_memory_write = 1'b0; mem_memory_read = 1'b0; mem_result = nres;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({dmem_req_valid, dmem_we, dmem_wstrb, dmem_wdata, dmem_addr, mem_misaligned,
         wb_result, wb_reg_file, wb_rd, mem_stall} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got req=%b we=%b strb=%h wd=%h a=%h mis=%b wb=%h rf=%b rd=%h st=%b want all 0",
               dmem_req_valid, dmem_we, dmem_wstrb, dmem_wdata, dmem_addr, mem_misaligned,
               wb_result, wb_reg_file, wb_rd, mem_stall);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_lb_signed();
    int s, n; logic u, w, t; logic [31:0] a, wd; logic [3:0] sb;
    do_access(32'h1003, 32'h0, 1'b0, 1'b1, 3'b000, 2'b00, 1'b1, 5'd3, 0, 0, 32'h80FF_FF00,
              1'b0, 32'h99, s, n, u, a, wd, w, sb, t);
    @(negedge clk);
    total++; if (s !== 3) begin bad++; $display("FAIL lb_stall: got %0d want 3", s); end
    total++; if (a !== 32'h1000 || w !== 1'b0 || n !== 1) begin
      bad++; $display("FAIL lb_req: addr=%h we=%b n=%0d want 1000 0 1", a, w, n); end
    total++; if (wb_result !== 32'hFFFF_FF80 || wb_reg_file !== 1'b1 || wb_rd !== 5'd3) begin
      bad++; $display("FAIL lb_wb: got %h rf=%b rd=%0d want ffffff80 1 3", wb_result, wb_reg_file,
                      wb_rd); end
  endtask

  task automatic test_sh_store();
    int s, n; logic u, w, t; logic [31:0] a, wd; logic [3:0] sb;
    do_access(32'h2002, 32'h1234_ABCD, 1'b1, 1'b0, 3'b000, 2'b01, 1'b1, 5'd4, 0, 0, 32'h0,
              1'b0, 32'h77, s, n, u, a, wd, w, sb, t);
    @(negedge clk);
    total++; if (wd !== 32'hABCD_ABCD || sb !== 4'b1100 || w !== 1'b1 || a !== 32'h2000) begin
      bad++; $display("FAIL sh_bus: wd=%h strb=%b we=%b a=%h want abcdabcd 1100 1 2000", wd, sb, w,
                      a); end
    total++; if (n !== 1 || s !== 2) begin
      bad++; $display("FAIL sh_count: req=%0d stall=%0d want 1 2", n, s); end
    total++; if (wb_reg_file !== 1'b0 || wb_result !== 32'h2002) begin
      bad++; $display("FAIL sh_wb: rf=%b wb=%h want 0 2002", wb_reg_file, wb_result); end
  endtask

  task automatic test_misaligned();
    int s, n; logic u, w, t; logic [31:0] a, wd; logic [3:0] sb;
    do_access(32'h3001, 32'h0, 1'b0, 1'b1, 3'b010, 2'b00, 1'b1, 5'd9, 0, 0, 32'h0,
              1'b0, 32'h31, s, n, u, a, wd, w, sb, t);
    @(negedge clk);
    total++; if (s !== 0 || n !== 0 || dmem_req_valid !== 1'b0) begin
      bad++; $display("FAIL mis_noreq: stall=%0d req=%0d valid=%b want 0 0 0", s, n,
                      dmem_req_valid); end
    total++; if (mem_misaligned !== 1'b1 || wb_reg_file !== 1'b0) begin
      bad++; $display("FAIL mis_pulse: mis=%b rf=%b want 1 0", mem_misaligned, wb_reg_file); end
    @(negedge clk);
    total++; if (mem_misaligned !== 1'b0 || mem_stall !== 1'b0) begin
      bad++; $display("FAIL mis_one_cycle: mis=%b stall=%b want 0 0", mem_misaligned, mem_stall);
    end
  endtask

  task automatic test_lhu_backpressure();
    int s, n; logic u, w, t; logic [31:0] a, wd; logic [3:0] sb;
    do_access(32'h4006, 32'h0, 1'b0, 1'b1, 3'b101, 2'b00, 1'b1, 5'd12, 5, 0, 32'hF00D_8001,
              1'b1, 32'h0, s, n, u, a, wd, w, sb, t);
    @(negedge clk);
    total++; if (u !== 1'b0 || n !== 1 || t !== 1'b0) begin
      bad++; $display("FAIL lhu_stable: unstable=%b req=%0d tmo=%b want 0 1 0", u, n, t); end
    total++; if (s !== 8) begin bad++; $display("FAIL lhu_stall: got %0d want 8", s); end
    total++; if (wb_result !== 32'h0000_F00D) begin
      bad++; $display("FAIL lhu_data: got %h want 0000f00d", wb_result); end
  endtask

  task automatic test_reset_in_wait();
    int s, n; logic u, w, t; logic [31:0] a, wd; logic [3:0] sb;
    @(posedge clk); #1;
    mem_result = 32'h40; mem_memory_read = 1'b1; mem_memory_load_type = 3'b010;
    mem_wb_reg_file = 1'b1; mem_wb_rd = 5'd7;
    @(posedge clk); #1; dmem_req_ready = 1'b1;
    @(posedge clk); #1; dmem_req_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_memory_read = 1'b0; mem_result = 32'h0; mem_wb_reg_file = 1'b0;
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total++; if (mem_stall !== 1'b0 || dmem_req_valid !== 1'b0 || wb_result !== 32'h0 ||
                 wb_reg_file !== 1'b0) begin
      bad++; $display("FAIL rst_wait: stall=%b valid=%b wb=%h rf=%b want 0 0 0 0", mem_stall,
                      dmem_req_valid, wb_result, wb_reg_file); end
    @(posedge clk); #1; dmem_rsp_valid = 1'b0;
    @(negedge clk);
    total++; if (wb_result !== 32'h0 || wb_reg_file !== 1'b0) begin
      bad++; $display("FAIL rst_late_rsp: wb=%h rf=%b want 0 0", wb_result, wb_reg_file); end
    do_access(32'h44, 32'h0, 1'b0, 1'b1, 3'b010, 2'b00, 1'b1, 5'd7, 0, 0, 32'h1357_9BDF,
              1'b0, 32'h0, s, n, u, a, wd, w, sb, t);
    @(negedge clk);
    total++; if (s !== 3 || wb_result !== 32'h1357_9BDF) begin
      bad++; $display("FAIL rst_recover: stall=%0d wb=%h want 3 13579bdf", s, wb_result); end
  endtask

  task automatic test_back_to_back();
    int s, n; logic u, w, t; logic [31:0] a, wd; logic [3:0] sb;
    do_access(32'h5008, 32'hCAFE_F00D, 1'b1, 1'b0, 3'b000, 2'b10, 1'b1, 5'd5, 0, 0, 32'h0,
              1'b0, 32'h55, s, n, u, a, wd, w, sb, t);
    @(negedge clk);
    total++; if (n !== 1 || wd !== 32'hCAFE_F00D || sb !== 4'hF || s !== 2) begin
      bad++; $display("FAIL b2b_sw: req=%0d wd=%h strb=%h stall=%0d want 1 cafef00d f 2", n, wd, sb,
                      s); end
    total++; if (dmem_req_valid !== 1'b0 || mem_stall !== 1'b0) begin
      bad++; $display("FAIL b2b_noreissue: valid=%b stall=%b want 0 0", dmem_req_valid, mem_stall);
    end
    @(negedge clk);
    total++; if (wb_result !== 32'h55 || wb_reg_file !== 1'b1 || dmem_req_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_alu: wb=%h rf=%b valid=%b want 55 1 0", wb_result, wb_reg_file,
                      dmem_req_valid); end
  endtask

  task automatic test_random();
    int s, n, kind, rdly, wdly, sz, es;
    logic u, w, t, ew, er, acc, mis, rf;
    logic [31:0] a, wd, res, op2, rdata, ewb;
    logic [3:0] sb;
    logic [2:0] lt;
    logic [1:0] st;
    logic [4:0] rd;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      res = $urandom; if ($urandom_range(0, 1) == 1) res = res & 32'hFFFF_FFFC;
      op2 = $urandom; rdata = $urandom; lt = 3'($urandom_range(0, 7));
      st = 2'($urandom_range(0, 3)); rf = 1'($urandom_range(0, 1)); rd = 5'($urandom);
      rdly = $urandom_range(0, 3); wdly = $urandom_range(0, 3);
      ew = (kind >= 2); er = (kind == 1); acc = (kind != 0);
      sz = acc_size(ew, lt, st);
      mis = acc && (res % sz != 0);
      es = (!acc || mis) ? 0 : ew ? 2 + rdly : 3 + rdly + wdly;
      ewb = (er && !mis) ? m_load(lt, res, rdata) : res;
      do_access(res, op2, kind[1], kind[0], lt, st, rf, rd, rdly, wdly, rdata, 1'b0, 32'h0,
                s, n, u, a, wd, w, sb, t);
      @(negedge clk);
      total++; if (s !== es || n !== ((acc && !mis) ? 1 : 0) || u !== 1'b0 || t !== 1'b0) begin
        bad++; $display("FAIL rnd_flow[%0d]: stall=%0d req=%0d unst=%b tmo=%b want %0d %0d 0 0",
                        i, s, n, u, t, es, (acc && !mis) ? 1 : 0); end
      if (acc && !mis) begin
        total++; if (a !== (res & 32'hFFFF_FFFC) || w !== ew ||
                     (ew && (sb !== m_strb(st, res) || wd !== m_wdata(st, op2)))) begin
          bad++; $display("FAIL rnd_bus[%0d]: a=%h we=%b strb=%b wd=%h want %h %b %b %h", i, a, w,
                          sb, wd, res & 32'hFFFF_FFFC, ew, m_strb(st, res), m_wdata(st, op2));
        end
      end
      total++; if (wb_result !== ewb || wb_reg_file !== (rf & ~ew & ~mis) || wb_rd !== rd ||
                   mem_misaligned !== mis) begin
        bad++; $display("FAIL rnd_wb[%0d]: wb=%h rf=%b rd=%0d mis=%b want %h %b %0d %b", i,
                        wb_result, wb_reg_file, wb_rd, mem_misaligned, ewb, rf & ~ew & ~mis, rd,
                        mis); end
    end
  endtask

  initial begin
    test_reset();
    test_lb_signed();
    test_sh_store();
    test_misaligned();
    test_lhu_backpressure();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The module SHALL have one clock and synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 Inputs from the EX/MEM register SHALL be:
- mem_result  input  32  ALU result / effective address
- mem_op2_selected  input  32  store data
- mem_memory_write  input  1  store request
- mem_memory_read  input  1  load request
- mem_memory_load_type  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes are treated as LW
- mem_memory_store_type  input  2  00 SB, 01 SH, 10 SW; 11 is treated as SW
- mem_wb_reg_file  input  1  register-file write enable
- mem_wb_rd  input  5  destination register
REQ-003 The data-bus signals SHALL be:
- dmem_req_valid  output  1  request valid
- dmem_req_ready  input  1  request accepted
- dmem_addr  output  32  word-aligned address ({mem_result[31:2],2'b00})
- dmem_we  output  1  write request
- dmem_wstrb  output  4  byte enables
- dmem_wdata  output  32  lane-replicated store data
- dmem_rsp_valid  input  1  read data valid
- dmem_rdata  input  32  read word
REQ-004 The pipeline-facing outputs SHALL be:
- mem_stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM
- mem_misaligned  output  1  one-cycle misaligned-access pulse
- wb_result  output  32  writeback data
- wb_reg_file  output  1  registered write enable
- wb_rd  output  5  registered destination register

Function
REQ-005 An access SHALL exist when mem_memory_read or mem_memory_write is 1; if both are 1, the write SHALL take priority and the read SHALL be ignored.
REQ-006 The FSM SHALL have the states IDLE, REQ, WAIT and DONE.
- IDLE with an aligned access: latch dmem_addr, dmem_we, dmem_wstrb and dmem_wdata; go to REQ.
- REQ: dmem_req_valid=1 with stable request signals; on dmem_req_ready=1 a write goes to DONE and a read goes to WAIT.
- WAIT: on dmem_rsp_valid=1, latch the extended load data and go to DONE.
- DONE: unconditionally return to IDLE.
REQ-007 mem_stall SHALL be combinational: 1 in IDLE with an aligned access, 1 in REQ, 1 in WAIT, and 0 otherwise (including DONE).
REQ-008 dmem_req_valid SHALL be 1 only in REQ, and no new request SHALL start in DONE.
REQ-009 dmem_rsp_valid SHALL be ignored outside WAIT.
REQ-010 Misalignment SHALL be detected as follows:
- LH, LHU or SH with addr[0]=1
- LW or SW with addr[1:0]!=0
REQ-011 A misaligned access SHALL issue no bus request and SHALL not stall. The next cycle it SHALL pulse mem_misaligned=1 for one cycle with wb_reg_file=0.
REQ-012 Stores SHALL drive the bus as follows:
- SB: wdata={4{op2[7:0]}}, wstrb=4'b0001<<addr[1:0]
- SH: wdata={2{op2[15:0]}}, wstrb=addr[1]?1100:0011
- SW: wdata=op2, wstrb=1111
REQ-013 Loads SHALL select the byte lane by addr[1:0] and the halfword by addr[1]. LB and LH SHALL sign-extend; LBU and LHU SHALL zero-extend.
REQ-014 The writeback registers (wb_result, wb_reg_file, wb_rd) SHALL update only on cycles with mem_stall=0:
- load in DONE: wb_result=extended load data
- otherwise: wb_result=mem_result
REQ-015 For a store, wb_reg_file SHALL be forced to 0.
REQ-016 With dmem_req_ready and dmem_rsp_valid asserted immediately, a load SHALL stall for 3 cycles (IDLE, REQ, WAIT), and its data SHALL appear on wb_result 4 cycles after it enters the stage. A store SHALL stall for 2 cycles.

Reset
REQ-017 Reset SHALL set the state to IDLE and all registered outputs to 0 (dmem_req_valid, dmem_we, dmem_wstrb, dmem_wdata, dmem_addr, mem_misaligned, wb_result, wb_reg_file, wb_rd), effective at the next clock edge.
REQ-018 Reset asserted during REQ or WAIT SHALL abandon the transaction, and a late dmem_rsp_valid SHALL not update any output.

Verification
REQ-019 LB at address 0x1003 with rdata=0x80FF_FF00, ready and rsp immediate -> wb_result=0xFFFF_FF80, wb_reg_file=1, and mem_stall high for exactly 3 cycles.
REQ-020 SH at address 0x2002 with op2=0x1234_ABCD -> one request with wdata=0xABCD_ABCD, wstrb=1100, dmem_we=1, and wb_reg_file=0.
REQ-021 LW at address 0x3001 -> no dmem_req_valid, mem_misaligned pulses for 1 cycle, and mem_stall stays 0.
REQ-022 LHU with dmem_req_ready held low for 5 cycles, and with rsp_valid also pulsed during REQ -> request signals stay stable, the early rsp_valid is ignored, and wb_result takes the WAIT-phase data, zero-extended.
REQ-023 Reset asserted in WAIT, then rsp_valid=1 -> state is IDLE, and wb_result and wb_reg_file stay 0.
REQ-024 Back-to-back SW then ALU op (mem_result=0x55) -> the SW completes, and wb_result=0x55 one cycle after DONE with no re-issue of the store.
